// File: rtl/rf_wb_queue.sv
// Write-back queue in front of the 32x32 register file write port: in-order FIFO
// with one-per-cycle drain and two combinational forwarding lookup ports.
module rf_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_wn,
    input  logic [31:0]      in_wd,
    input  logic             drain_en,
    output logic [4:0]       wn,
    output logic [31:0]      wd,
    output logic             w,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             fwd1_hit,
    output logic [31:0]      fwd1_data,
    output logic             fwd2_hit,
    output logic [31:0]      fwd2_data,
    output logic [PTR_W:0]   count
);

    logic [4:0]       r_wn [DEPTH];
    logic [31:0]      r_wd [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_idx;

    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = !w_empty && drain_en;

    assign in_ready = !w_full;
    assign w        = w_pop;
    assign wn       = r_wn[r_head];
    assign wd       = r_wd[r_head];
    assign count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop)  r_vld[r_head] <= 1'b0;
            if (w_push) r_vld[r_tail] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wn[r_tail] <= in_wn;
            r_wd[r_tail] <= in_wd;
        end
    end

    // Scan oldest to youngest starting at head; the last match is the youngest.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        w_idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (r_vld[w_idx] && (r_wn[w_idx] == rs1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = r_wd[w_idx];
            end
            if (r_vld[w_idx] && (r_wn[w_idx] == rs2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = r_wd[w_idx];
            end
        end
    end

endmodule
